// File: rtl/logic_gate_pkg.sv
// Shared operation encodings for the logic gate pipeline and its bench.
package logic_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_XNOR  = 3'b011,
    OP_NAND  = 3'b100,
    OP_NOR   = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSA = 3'b111
  } op_e;

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Operand/result bus of the logic gate pipeline; slave is the pipeline side.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output a, b, op, in_valid, out_ready,
    input  in_ready, x, out_valid, count
  );

  modport slave (
    input  a, b, op, in_valid, out_ready,
    output in_ready, x, out_valid, count
  );
endinterface

// File: rtl/logic_gate_op.sv
// Combinational bitwise operation decoder feeding the first pipeline stage.
module logic_gate_op
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] x_o
);

  always_comb begin
    x_o = a_i;
    case (op_e'(op_i))
      OP_AND:   x_o = a_i & b_i;
      OP_OR:    x_o = a_i | b_i;
      OP_XOR:   x_o = a_i ^ b_i;
      OP_XNOR:  x_o = ~(a_i ^ b_i);
      OP_NAND:  x_o = ~(a_i & b_i);
      OP_NOR:   x_o = ~(a_i | b_i);
      OP_NOTA:  x_o = ~a_i;
      OP_PASSA: x_o = a_i;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Elastic DEPTH-stage pipeline carrying bitwise gate results; bubbles collapse
// under back-pressure and COUNT tracks occupancy.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input logic             clk,
  input logic             rst_n,
  logic_gate_pipe_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]            res;
  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            adv, load;
  logic [CW-1:0]               count_q, count_d;
  logic                        acc, xfer;

  logic_gate_op #(.WIDTH(WIDTH)) u_op (
    .a_i  (bus.a),
    .b_i  (bus.b),
    .op_i (bus.op),
    .x_o  (res)
  );

  // Ready propagates from the output end back to stage 0 in one pass.
  always_comb begin
    adv = '0;
    load = '0;
    adv[DEPTH-1]  = vld_q[DEPTH-1] & bus.out_ready;
    load[DEPTH-1] = ~vld_q[DEPTH-1] | adv[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k]  = vld_q[k] & load[k+1];
      load[k] = ~vld_q[k] | adv[k];
    end
  end

  assign acc  = bus.in_valid & load[0];
  assign xfer = adv[DEPTH-1];

  always_comb begin
    count_d = count_q;
    case ({acc, xfer})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (load[0]) begin
        vld_q[0] <= bus.in_valid;
        if (bus.in_valid) data_q[0] <= res;
      end
      // Data registers only move with valid data so bubbles keep X stable.
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = vld_q[DEPTH-1];
  assign bus.x         = data_q[DEPTH-1];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomized and directed checks of logic_gate_pipe at DEPTH 3, 1 and 8 against
// a queue-based occupancy model with truth-table results.
module tb_logic_gate_pipe;
  import logic_gate_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0][7:0] a_s, b_s, x_s;
  logic [2:0][2:0] op_s;
  logic [2:0]      iv_s, or_s, ir_s, ov_s;
  logic [2:0][3:0] cnt_s;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 3 : (g == 1) ? 1 : 8;
    logic_gate_pipe_if #(.WIDTH(8), .DEPTH(D)) bif ();
    assign bif.a         = a_s[g];
    assign bif.b         = b_s[g];
    assign bif.op        = op_s[g];
    assign bif.in_valid  = iv_s[g];
    assign bif.out_ready = or_s[g];
    assign ir_s[g]  = bif.in_ready;
    assign ov_s[g]  = bif.out_valid;
    assign x_s[g]   = bif.x;
    assign cnt_s[g] = 4'(bif.count);
    logic_gate_pipe #(.WIDTH(8), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
    );
  end

  typedef logic [7:0] bq_t[$];
  bq_t        q [3];
  int         n_chk = 0, n_err = 0;
  int         tot_acc [3] = '{0, 0, 0};
  int         tot_xf  [3] = '{0, 0, 0};
  int         cyc_n = 0;
  logic [2:0] acc_f, xf_f;
  logic       ov0_snap;
  logic [7:0] x0_snap;
  logic [7:0] got0[$];
  int         got0_cyc[$];

  function automatic int dep(int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : 8;
  endfunction

  // Per-bit truth table indexed by {a,b}.
  function automatic logic [7:0] gate_ref(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    logic [3:0] tt;
    logic [7:0] r;
    case (op_e'(op))
      OP_AND:  tt = 4'b1000;
      OP_OR:   tt = 4'b1110;
      OP_XOR:  tt = 4'b0110;
      OP_XNOR: tt = 4'b1001;
      OP_NAND: tt = 4'b0111;
      OP_NOR:  tt = 4'b0001;
      OP_NOTA: tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic mr;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mr = (q[i].size() < dep(i)) || or_s[i];
      chk("in_ready", 64'(ir_s[i]), 64'(mr));
      chk("count", 64'(cnt_s[i]), 64'(q[i].size()));
      acc_f[i] = iv_s[i] && mr;
      xf_f[i]  = ov_s[i] && or_s[i];
      if (ov_s[i]) begin
        if (q[i].size() == 0) chk("spurious_ov", 64'(ov_s[i]), 64'(0));
        else if (or_s[i]) chk("x_order", 64'(x_s[i]), 64'(q[i][0]));
      end
    end
    ov0_snap = ov_s[0];
    x0_snap  = x_s[0];
    if (xf_f[0]) begin
      got0.push_back(x_s[0]);
      got0_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (xf_f[i] && q[i].size() != 0) begin
        void'(q[i].pop_front());
        tot_xf[i]++;
      end
      if (acc_f[i]) begin
        q[i].push_back(gate_ref(a_s[i], b_s[i], op_s[i]));
        tot_acc[i]++;
      end
    end
    cyc_n++;
    #1;
  endtask

  task automatic lat_chk(input string tag, input logic [7:0] xexp);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk(tag, 64'(ov0_snap), 64'(k == 3));
      if (k == 3) chk({tag, "_x"}, 64'(x0_snap), 64'(xexp));
    end
  endtask

  task automatic drain0();
    int g = 0;
    or_s[0] = 1'b1;
    iv_s[0] = 1'b0;
    while (q[0].size() != 0 && g < 50) begin
      step();
      g++;
    end
    if (q[0].size() != 0) chk("drain_timeout", 64'(q[0].size()), 64'(0));
    step();
  endtask

  initial begin
    logic [7:0] exp034 [8];
    int base_a, base_x, guard;
    bit stall;
    exp034 = '{8'h0A, 8'hAF, 8'hA5, 8'h5A, 8'hF5, 8'h50, 8'h55, 8'hAA};
    a_s = '0; b_s = '0; op_s = '0; iv_s = '0; or_s = '0;

    #1;
    chk("rst_ov", 64'(ov_s[0]), 64'(0));
    chk("rst_x", 64'(x_s[0]), 64'(0));
    chk("rst_cnt", 64'(cnt_s[0]), 64'(0));
    chk("rst_ir", 64'(ir_s[0]), 64'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single XNOR beat through DEPTH=3.
    a_s[0] = 8'hF0; b_s[0] = 8'hCC; op_s[0] = OP_XNOR; iv_s[0] = 1'b1; or_s[0] = 1'b1;
    step();
    chk("acc033", 64'(acc_f[0]), 64'(1));
    iv_s[0] = 1'b0;
    lat_chk("lat033", 8'hC3);

    // All eight ops back to back.
    got0.delete(); got0_cyc.delete();
    a_s[0] = 8'hAA; b_s[0] = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      op_s[0] = 3'(k); iv_s[0] = 1'b1;
      step();
    end
    drain0();
    chk("n034", 64'(got0.size()), 64'(8));
    for (int k = 0; k < 8 && k < got0.size(); k++) begin
      chk("x034", 64'(got0[k]), 64'(exp034[k]));
      chk("cyc034", 64'(got0_cyc[k] - got0_cyc[0]), 64'(k));
    end

    // Back-pressure: fill to DEPTH then stall.
    base_a = tot_acc[0]; base_x = tot_xf[0];
    or_s[0] = 1'b0; iv_s[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a_s[0] = 8'($urandom); b_s[0] = 8'($urandom); op_s[0] = 3'($urandom);
      step();
    end
    chk("acc035", 64'(tot_acc[0] - base_a), 64'(3));
    chk("cnt035", 64'(cnt_s[0]), 64'(3));
    chk("ir035", 64'(ir_s[0]), 64'(0));
    drain0();
    chk("xf035", 64'(tot_xf[0] - base_x), 64'(3));

    // Full pipe streams: accept and emit together.
    or_s[0] = 1'b0; iv_s[0] = 1'b1;
    repeat (3) step();
    or_s[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_s[0] = 8'($urandom); op_s[0] = 3'($urandom);
      step();
      chk("acc036", 64'(acc_f[0]), 64'(1));
      chk("xf036", 64'(xf_f[0]), 64'(1));
      chk("cnt036", 64'(cnt_s[0]), 64'(3));
    end
    drain0();

    // Asynchronous reset with beats in flight.
    a_s[0] = 8'hF0; b_s[0] = 8'h00; op_s[0] = OP_PASSA; iv_s[0] = 1'b1; or_s[0] = 1'b1;
    repeat (2) step();
    iv_s[0] = 1'b0;
    step();
    chk("pre_rst_ov", 64'(ov_s[0]), 64'(1));
    chk("pre_rst_x", 64'(x_s[0]), 64'(8'hF0));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ov", 64'(ov_s[0]), 64'(0));
    chk("arst_x", 64'(x_s[0]), 64'(0));
    chk("arst_cnt", 64'(cnt_s[0]), 64'(0));
    chk("arst_ir", 64'(ir_s[0]), 64'(1));
    for (int i = 0; i < 3; i++) q[i].delete();
    #1 rst_n = 1'b1;
    a_s[0] = 8'h3C; b_s[0] = 8'h0F; op_s[0] = OP_XOR; iv_s[0] = 1'b1;
    step();
    chk("acc037", 64'(acc_f[0]), 64'(1));
    iv_s[0] = 1'b0;
    lat_chk("lat037", 8'h33);

    // Random traffic on DEPTH=1 and DEPTH=8 side by side.
    guard = 0;
    while ((tot_acc[1] < 1000 || tot_acc[2] < 1000 ||
            q[1].size() != 0 || q[2].size() != 0) && guard < 20000) begin
      stall = ((guard / 40) % 3) == 1;
      for (int i = 1; i < 3; i++) begin
        iv_s[i] = (tot_acc[i] < 1000) && ($urandom % 3 != 0);
        a_s[i]  = 8'($urandom);
        b_s[i]  = 8'($urandom);
        op_s[i] = 3'($urandom);
        or_s[i] = stall ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
      end
      step();
      guard++;
    end
    if (guard >= 20000) chk("rand_timeout", 64'(guard), 64'(0));
    for (int i = 1; i < 3; i++) begin
      chk("rand_acc", 64'(tot_acc[i]), 64'(1000));
      chk("rand_xf", 64'(tot_xf[i]), 64'(1000));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
